// File: rtl/seg7_readback.sv
// Seven-segment readback monitor: decodes sampled segment buses back to BCD digits,
// accepting a pattern only after it has been stable for STABLE_CYC enabled samples.
module seg7_readback #(
   parameter int unsigned N_DIG      = 4,
   parameter bit          SEG_AL     = 1'b1,
   parameter int unsigned STABLE_CYC = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 clr_err_i,
   input  logic [7*N_DIG-1:0]   hex_in_i,
   output logic [4*N_DIG-1:0]   digit_o,
   output logic [N_DIG-1:0]     dig_valid_o,
   output logic [N_DIG-1:0]     upd_o,
   output logic [CNT_W-1:0]     err_cnt_o,
   output logic                 err_flag_o
);

   localparam int unsigned CW     = $clog2(STABLE_CYC + 1);
   localparam logic [CW-1:0] CntMax  = CW'(STABLE_CYC);
   localparam logic [CW-1:0] CntLast = CW'(STABLE_CYC - 1);
   localparam int unsigned ErrMax = (1 << CNT_W) - 1;

   logic [N_DIG-1:0][6:0]    p_q, p_d;
   logic [N_DIG-1:0][CW-1:0] cnt_q, cnt_d;
   logic [4*N_DIG-1:0]       digit_q, digit_d;
   logic [N_DIG-1:0]         valid_q, valid_d;
   logic [N_DIG-1:0]         upd_q, upd_d;
   logic [CNT_W-1:0]         err_cnt_q, err_cnt_d;
   logic                     err_flag_q, err_flag_d;

   logic [6:0]   n;
   logic         acc;
   logic [5:0]   dec;
   int unsigned  nerr;
   int unsigned  sum;

   // Returns {valid, error, digit}
   function automatic logic [5:0] decode(input logic [6:0] s);
      case (s)
         7'h3F:   decode = {2'b10, 4'h0};
         7'h06:   decode = {2'b10, 4'h1};
         7'h5B:   decode = {2'b10, 4'h2};
         7'h4F:   decode = {2'b10, 4'h3};
         7'h66:   decode = {2'b10, 4'h4};
         7'h6D:   decode = {2'b10, 4'h5};
         7'h7D:   decode = {2'b10, 4'h6};
         7'h07:   decode = {2'b10, 4'h7};
         7'h7F:   decode = {2'b10, 4'h8};
         7'h6F:   decode = {2'b10, 4'h9};
         7'h00:   decode = {2'b00, 4'hF};
         default: decode = {2'b01, 4'hE};
      endcase
   endfunction

   always_comb begin
      p_d     = p_q;
      cnt_d   = cnt_q;
      digit_d = digit_q;
      valid_d = valid_q;
      upd_d   = '0;
      n       = '0;
      acc     = 1'b0;
      dec     = '0;
      nerr    = 0;
      for (int i = 0; i < int'(N_DIG); i++) begin
         n   = SEG_AL ? ~hex_in_i[7*i +: 7] : hex_in_i[7*i +: 7];
         acc = 1'b0;
         if (en_i) begin
            if (n == p_q[i]) begin
               // Saturating run counter: accept fires only on the step into CntMax
               if (cnt_q[i] != CntMax) begin
                  cnt_d[i] = cnt_q[i] + CW'(1);
                  acc      = (cnt_q[i] == CntLast);
               end
            end else begin
               p_d[i]   = n;
               cnt_d[i] = CW'(1);
               acc      = (STABLE_CYC == 1);
            end
         end
         if (acc) begin
            dec              = decode(n);
            digit_d[4*i +: 4] = dec[3:0];
            valid_d[i]       = dec[5];
            upd_d[i]         = ({dec[3:0], dec[5]} != {digit_q[4*i +: 4], valid_q[i]});
            if (dec[4]) nerr = nerr + 1;
         end
      end
      // Clear takes effect first, then this cycle's error events are added
      sum = (clr_err_i ? 0 : int'(err_cnt_q)) + nerr;
      if (sum > ErrMax) sum = ErrMax;
      err_cnt_d  = CNT_W'(sum);
      err_flag_d = (err_flag_q & ~clr_err_i) | (nerr != 0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         p_q        <= '0;
         cnt_q      <= '0;
         digit_q    <= '1;
         valid_q    <= '0;
         upd_q      <= '0;
         err_cnt_q  <= '0;
         err_flag_q <= 1'b0;
      end else begin
         p_q        <= p_d;
         cnt_q      <= cnt_d;
         digit_q    <= digit_d;
         valid_q    <= valid_d;
         upd_q      <= upd_d;
         err_cnt_q  <= err_cnt_d;
         err_flag_q <= err_flag_d;
      end
   end

   assign digit_o     = digit_q;
   assign dig_valid_o = valid_q;
   assign upd_o       = upd_q;
   assign err_cnt_o   = err_cnt_q;
   assign err_flag_o  = err_flag_q;

endmodule

// File: tb/tb_seg7_readback.sv
// Directed bench for seg7_readback (4 digits, active-low segments, 4-sample filter, 2-bit counter).
module tb_seg7_readback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        clr_err;
   logic [3:0][6:0] seg;  // active-high patterns, digit 0 at [0]
   logic [27:0] hex_in;
   logic [15:0] digit;
   logic [3:0]  dig_valid;
   logic [3:0]  upd;
   logic [1:0]  err_cnt;
   logic        err_flag;

   int total = 0;
   int bad   = 0;

   assign hex_in = ~seg;

   always #5 clk = ~clk;

   seg7_readback #(
      .N_DIG     (4),
      .SEG_AL    (1'b1),
      .STABLE_CYC(4),
      .CNT_W     (2)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .en_i       (en),
      .clr_err_i  (clr_err),
      .hex_in_i   (hex_in),
      .digit_o    (digit),
      .dig_valid_o(dig_valid),
      .upd_o      (upd),
      .err_cnt_o  (err_cnt),
      .err_flag_o (err_flag)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      en      = 1'b1;
      clr_err = 1'b0;
      seg     = 28'($urandom);
      #12;
      check("rst_digit", 32'(digit), 32'hFFFF);
      check("rst_valid", 32'(dig_valid), 32'h0);
      check("rst_upd", 32'(upd), 32'h0);
      check("rst_errcnt", 32'(err_cnt), 32'h0);
      check("rst_errflag", 32'(err_flag), 32'h0);

      // Accept digit "2" after exactly four edges
      @(posedge clk);
      #1;
      seg    = '0;
      seg[0] = 7'h5B;
      rst_n  = 1'b1;
      step(3);
      check("acc2_early", 32'(digit[3:0]), 32'hF);
      check("acc2_early_upd", 32'(upd), 32'h0);
      step(1);
      check("acc2_digit", 32'(digit[3:0]), 32'h2);
      check("acc2_valid", 32'(dig_valid), 32'h1);
      check("acc2_upd", 32'(upd), 32'h1);
      for (int e = 5; e <= 20; e++) begin
         step(1);
         check("acc2_noupd", 32'(upd), 32'h0);
      end

      // Glitch: "3" for two samples is dropped, then "8" accepted
      seg[0] = 7'h4F;
      step(2);
      seg[0] = 7'h7F;
      step(3);
      check("glitch_hold", 32'(digit[3:0]), 32'h2);
      check("glitch_noupd", 32'(upd), 32'h0);
      step(1);
      check("glitch_8", 32'(digit[3:0]), 32'h8);
      check("glitch_upd", 32'(upd), 32'h1);
      step(1);
      check("glitch_upd_off", 32'(upd), 32'h0);

      // Illegal pattern on digit 1, counted once per run
      seg[1] = 7'h49;
      step(4);
      check("ill_digit", 32'(digit[7:4]), 32'hE);
      check("ill_valid", 32'(dig_valid), 32'h1);
      check("ill_upd", 32'(upd), 32'h2);
      check("ill_cnt", 32'(err_cnt), 32'h1);
      check("ill_flag", 32'(err_flag), 32'h1);
      step(6);
      check("ill_cnt_held", 32'(err_cnt), 32'h1);
      clr_err = 1'b1;
      step(1);
      clr_err = 1'b0;
      check("clr_cnt", 32'(err_cnt), 32'h0);
      check("clr_flag", 32'(err_flag), 32'h0);
      check("clr_digit", 32'(digit[7:4]), 32'hE);

      // Five separate illegal runs saturate the 2-bit counter at 3
      for (int r = 1; r <= 5; r++) begin
         seg[1] = 7'h00;
         step(5);
         check("sat_blank", 32'(digit[7:4]), 32'hF);
         seg[1] = 7'h49;
         step(5);
         check("sat_cnt", 32'(err_cnt), (r > 3) ? 32'h3 : 32'(r));
      end
      clr_err = 1'b1;
      step(1);
      clr_err = 1'b0;
      check("sat_clr", 32'(err_cnt), 32'h0);

      // Two digits going illegal on the same edge add two
      seg[2] = 7'h49;
      seg[3] = 7'h49;
      step(4);
      check("dual_cnt", 32'(err_cnt), 32'h2);
      check("dual_digits", 32'(digit[15:8]), 32'hEE);
      check("dual_upd", 32'(upd), 32'hC);

      // Clear coinciding with a new error event leaves count at one
      seg[2] = 7'h00;
      step(4);
      check("pre_clr_cnt", 32'(err_cnt), 32'h2);
      seg[2] = 7'h49;
      step(3);
      clr_err = 1'b1;
      step(1);
      clr_err = 1'b0;
      check("clr_evt_cnt", 32'(err_cnt), 32'h1);
      check("clr_evt_flag", 32'(err_flag), 32'h1);

      // Enable gap: run resumes after en returns
      seg[0] = 7'h06;
      step(2);
      en = 1'b0;
      step(5);
      check("en_hold", 32'(digit[3:0]), 32'h8);
      check("en_upd", 32'(upd), 32'h0);
      en = 1'b1;
      step(1);
      check("en_third", 32'(digit[3:0]), 32'h8);
      step(1);
      check("en_accept", 32'(digit[3:0]), 32'h1);
      check("en_accept_upd", 32'(upd), 32'h1);

      // Asynchronous reset mid-run
      seg[0] = 7'h6D;
      step(2);
      rst_n = 1'b0;
      #1;
      check("arst_digit", 32'(digit), 32'hFFFF);
      check("arst_valid", 32'(dig_valid), 32'h0);
      check("arst_cnt", 32'(err_cnt), 32'h0);
      check("arst_flag", 32'(err_flag), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
